// File: rtl/ft2232h_pkg.sv
// Shared definitions for the FT2232H synchronous FT245 receive and transmit paths.
// State codes are common to both directions so debug probes decode them identically.
package ft2232h_pkg;

  localparam int FT_BYTE_W  = 8;
  localparam int FT_CNT_W   = 32;
  localparam int FT_STATE_W = 2;

  typedef logic [FT_STATE_W-1:0] ft_state_t;

  localparam ft_state_t FT_IDLE = 2'd0;
  localparam ft_state_t FT_OE   = 2'd1;
  localparam ft_state_t FT_READ = 2'd2;

  // OE# is asserted in every state that owns the bus for reading.
  function automatic logic ftOeN(input ft_state_t s);
    return !((s == FT_OE) || (s == FT_READ));
  endfunction

  function automatic logic ftRdN(input ft_state_t s);
    return s != FT_READ;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head entry is always visible on data_o.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo_fwft
  import ft2232h_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = FT_BYTE_W
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          valid_o,
  output logic [AW:0]   level_o
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wrPtr;
  logic [AW:0]  r_rdPtr;
  logic [AW:0]  w_level;
  logic         w_empty;
  logic         w_full;
  logic         w_doPush;
  logic         w_doPop;

  assign w_level = r_wrPtr - r_rdPtr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == (AW+1)'(DEPTH));

  // A pop on a full FIFO frees the very slot the push lands in, so both may proceed.
  assign w_doPop  = pop_i & ~w_empty;
  assign w_doPush = push_i & (~w_full | w_doPop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= data_i;
  end

  assign data_o  = r_mem[r_rdPtr[AW-1:0]];
  assign valid_o = ~w_empty;
  assign level_o = w_level;

endmodule

// File: rtl/ft2232h_rx_reader.sv
// Host-to-FPGA reader for the FT2232H synchronous FIFO interface on the 60 MHz CLKOUT.
// OE#/RD# are registered from the next state; bytes land in an FWFT buffer for a valid/ready consumer.
module ft2232h_rx_reader
  import ft2232h_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 rxf_n_i,
  input  logic [FT_BYTE_W-1:0] byte_i,
  output logic                 oe_n_o,
  output logic                 rd_n_o,
  output logic [FT_BYTE_W-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [AW:0]          level_o,
  output logic [FT_CNT_W-1:0]  rx_count_o,
  output logic                 activity_o
);

  ft_state_t             r_state;
  ft_state_t             w_nextState;
  logic                  r_oeN;
  logic                  r_rdN;
  logic [FT_CNT_W-1:0]   r_rxCount;
  logic                  r_activity;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic [AW:0]           w_level;
  logic [AW+1:0]         w_levelNext;
  logic                  w_roomForTwo;
  logic                  w_roomAfter;

  assign w_push = ~r_rdN & ~rxf_n_i;
  assign w_pop  = w_valid & ready_i;

  // Stop decisions look at the occupancy after this edge, so the FIFO can never overflow.
  assign w_levelNext  = (AW+2)'(w_level) + (AW+2)'(w_push) - (AW+2)'(w_pop);
  assign w_roomForTwo = (w_level <= (AW+1)'(DEPTH - 2));
  assign w_roomAfter  = (w_levelNext < (AW+2)'(DEPTH));

  always_comb begin
    w_nextState = FT_IDLE;
    case (r_state)
      FT_IDLE: w_nextState = (en_i && !rxf_n_i && w_roomForTwo) ? FT_OE : FT_IDLE;
      FT_OE:   w_nextState = (rxf_n_i || !en_i) ? FT_IDLE : FT_READ;
      FT_READ: w_nextState = (!rxf_n_i && en_i && w_roomAfter) ? FT_READ : FT_IDLE;
      default: w_nextState = FT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= FT_IDLE;
      r_oeN   <= 1'b1;
      r_rdN   <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_oeN   <= ftOeN(w_nextState);
      r_rdN   <= ftRdN(w_nextState);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rxCount  <= '0;
      r_activity <= 1'b0;
    end else if (w_push) begin
      r_rxCount  <= r_rxCount + 1'b1;
      r_activity <= ~r_activity;
    end
  end

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (FT_BYTE_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_push),
    .data_i  (byte_i),
    .pop_i   (ready_i),
    .data_o  (data_o),
    .valid_o (w_valid),
    .level_o (w_level)
  );

  assign oe_n_o     = r_oeN;
  assign rd_n_o     = r_rdN;
  assign valid_o    = w_valid;
  assign level_o    = w_level;
  assign rx_count_o = r_rxCount;
  assign activity_o = r_activity;

endmodule

// File: tb/tb_ft2232h_rx_reader.sv
// Directed bench for ft2232h_rx_reader: a per-cycle vector table plus host-model sequences.
// The host model serves a byte list and advances only on edges where RD# and RXF# are both low.
module tb_ft2232h_rx_reader;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        en_i;
  logic        rxf_n_i;
  logic [7:0]  byte_i;
  logic        oe_n_o;
  logic        rd_n_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic [AW:0] level_o;
  logic [31:0] rx_count_o;
  logic        activity_o;

  ft2232h_rx_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .rxf_n_i    (rxf_n_i),
    .byte_i     (byte_i),
    .oe_n_o     (oe_n_o),
    .rd_n_o     (rd_n_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .rx_count_o (rx_count_o),
    .activity_o (activity_o)
  );

  always #8 clk_i = ~clk_i;

  typedef struct {
    logic        en;
    logic        rxfN;
    logic [7:0]  byteIn;
    logic        ready;
    logic        expOeN;
    logic        expRdN;
    logic        expValid;
    logic [7:0]  expData;
    logic [4:0]  expLevel;
    logic [31:0] expCount;
    logic        expAct;
  } vec_t;

  vec_t vecs[11];

  int checks = 0;
  int failures = 0;

  logic [7:0] hostQ[$];
  int  hostIdx;
  int  outIdx;
  int  pushCount;
  int  toggles;
  int  rdRises;
  bit  hostHold;
  logic prevAct;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearModel();
    hostQ.delete();
    hostIdx   = 0;
    outIdx    = 0;
    pushCount = 0;
    toggles   = 0;
    rdRises   = 0;
    hostHold  = 1'b0;
    prevAct   = 1'b0;
  endtask

  task automatic loadRamp(input logic [7:0] first, input int count);
    for (int i = 0; i < count; i++) hostQ.push_back(first + 8'(i));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic applyStimulus();
    logic willPush;
    logic willPop;
    logic prevRd;
    rxf_n_i  = hostHold || (hostIdx >= hostQ.size());
    byte_i   = (hostIdx < hostQ.size()) ? hostQ[hostIdx] : 8'h00;
    willPush = !rd_n_o && !rxf_n_i;
    willPop  = valid_o && ready_i;
    if (willPush) checkOutput("room_on_push", 32'(level_o < 5'(DEPTH)), 32'd1);
    if (willPop) begin
      if (outIdx < hostQ.size()) checkOutput("stream_byte", 32'(data_o), 32'(hostQ[outIdx]));
      else checkOutput("stream_extra_byte", 32'(outIdx), 32'(hostQ.size()));
      outIdx++;
    end
    prevRd = rd_n_o;
    @(posedge clk_i);
    @(negedge clk_i);
    if (willPush) begin
      hostIdx++;
      pushCount++;
    end
    if (activity_o !== prevAct) toggles++;
    prevAct = activity_o;
    if (!prevRd && rd_n_o) rdRises++;
  endtask

  task automatic runUntilDrained(input int target, input int budget);
    int n = 0;
    while (outIdx < target && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_done", 32'(outIdx), 32'(target));
  endtask

  task automatic runUntilPushes(input int target, input int budget);
    int n = 0;
    while (pushCount < target && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("push_target", 32'(pushCount), 32'(target));
  endtask

  task automatic checkIdleEmpty(input string tag);
    checkOutput({tag, "_oe_n"}, 32'(oe_n_o), 32'd1);
    checkOutput({tag, "_rd_n"}, 32'(rd_n_o), 32'd1);
    checkOutput({tag, "_valid"}, 32'(valid_o), 32'd0);
    checkOutput({tag, "_level"}, 32'(level_o), 32'd0);
    checkOutput({tag, "_count"}, rx_count_o, 32'd0);
    checkOutput({tag, "_activity"}, 32'(activity_o), 32'd0);
  endtask

  // Reset is asserted between clock edges and checked before the next edge arrives.
  task automatic doReset();
    @(negedge clk_i);
    rxf_n_i = 1'b1;
    rst_n_i = 1'b0;
    #2;
    checkIdleEmpty("reset_async");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    clearModel();
  endtask

  task automatic applyVector(input int idx);
    en_i    = vecs[idx].en;
    rxf_n_i = vecs[idx].rxfN;
    byte_i  = vecs[idx].byteIn;
    ready_i = vecs[idx].ready;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput($sformatf("vec%0d_oe_n", idx), 32'(oe_n_o), 32'(vecs[idx].expOeN));
    checkOutput($sformatf("vec%0d_rd_n", idx), 32'(rd_n_o), 32'(vecs[idx].expRdN));
    checkOutput($sformatf("vec%0d_valid", idx), 32'(valid_o), 32'(vecs[idx].expValid));
    if (vecs[idx].expValid)
      checkOutput($sformatf("vec%0d_data", idx), 32'(data_o), 32'(vecs[idx].expData));
    checkOutput($sformatf("vec%0d_level", idx), 32'(level_o), 32'(vecs[idx].expLevel));
    checkOutput($sformatf("vec%0d_count", idx), rx_count_o, vecs[idx].expCount);
    checkOutput($sformatf("vec%0d_activity", idx), 32'(activity_o), 32'(vecs[idx].expAct));
  endtask

  initial begin
    // Single byte, then enable/RXF# gating in IDLE and in the OE turnaround cycle.
    vecs[0]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 32'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 32'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 32'd1, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 32'd1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 32'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 32'd1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 32'd1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 32'd1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 32'd1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 32'd1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 32'd1, 1'b1};

    rst_n_i = 1'b0;
    en_i    = 1'b0;
    rxf_n_i = 1'b1;
    byte_i  = 8'h00;
    ready_i = 1'b0;
    clearModel();

    doReset();
    checkIdleEmpty("after_release");
    for (int i = 0; i < 11; i++) applyVector(i);

    $display("[TB] burst of 40 bytes");
    doReset();
    en_i = 1'b1;
    ready_i = 1'b1;
    loadRamp(8'h00, 40);
    runUntilDrained(40, 200);
    applyStimulus();
    checkOutput("burst_count", rx_count_o, 32'd40);
    checkOutput("burst_toggles", 32'(toggles), 32'd40);
    checkOutput("burst_rd_rises", 32'(rdRises), 32'd1);
    checkOutput("burst_rd_n_end", 32'(rd_n_o), 32'd1);
    checkOutput("burst_level_end", 32'(level_o), 32'd0);

    $display("[TB] backpressure with 20 bytes offered");
    doReset();
    en_i = 1'b1;
    ready_i = 1'b0;
    loadRamp(8'h00, 20);
    for (int i = 0; i < 30; i++) applyStimulus();
    checkOutput("bp_pushes", 32'(pushCount), 32'd16);
    checkOutput("bp_level", 32'(level_o), 32'd16);
    checkOutput("bp_rd_n", 32'(rd_n_o), 32'd1);
    checkOutput("bp_oe_n", 32'(oe_n_o), 32'd1);
    checkOutput("bp_count", rx_count_o, 32'd16);
    ready_i = 1'b1;
    runUntilDrained(20, 200);
    checkOutput("bp_count_final", rx_count_o, 32'd20);
    checkOutput("bp_pushes_final", 32'(pushCount), 32'd20);

    $display("[TB] RXF# gap after 5 bytes");
    doReset();
    en_i = 1'b1;
    ready_i = 1'b1;
    loadRamp(8'h30, 12);
    runUntilPushes(5, 50);
    hostHold = 1'b1;
    applyStimulus();
    checkOutput("gap_oe_n", 32'(oe_n_o), 32'd1);
    checkOutput("gap_rd_n", 32'(rd_n_o), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("gap_pushes", 32'(pushCount), 32'd5);
    hostHold = 1'b0;
    applyStimulus();
    checkOutput("gap_turn_oe_n", 32'(oe_n_o), 32'd0);
    checkOutput("gap_turn_rd_n", 32'(rd_n_o), 32'd1);
    applyStimulus();
    checkOutput("gap_read_rd_n", 32'(rd_n_o), 32'd0);
    checkOutput("gap_pushes_before_read", 32'(pushCount), 32'd5);
    runUntilDrained(12, 100);
    checkOutput("gap_count", rx_count_o, 32'd12);

    $display("[TB] enable dropped at byte 7");
    doReset();
    en_i = 1'b1;
    ready_i = 1'b1;
    loadRamp(8'h70, 12);
    runUntilPushes(6, 50);
    en_i = 1'b0;
    applyStimulus();
    checkOutput("en_last_push", 32'(pushCount), 32'd7);
    checkOutput("en_oe_n", 32'(oe_n_o), 32'd1);
    checkOutput("en_rd_n", 32'(rd_n_o), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("en_count", rx_count_o, 32'd7);
    checkOutput("en_drained", 32'(outIdx), 32'd7);
    checkOutput("en_idle_rd_n", 32'(rd_n_o), 32'd1);

    $display("[TB] async reset mid-read");
    doReset();
    en_i = 1'b1;
    ready_i = 1'b0;
    loadRamp(8'h90, 12);
    runUntilPushes(6, 50);
    checkOutput("mid_level", 32'(level_o), 32'd6);
    checkOutput("mid_rd_n", 32'(rd_n_o), 32'd0);
    doReset();
    en_i = 1'b1;
    ready_i = 1'b1;
    loadRamp(8'h50, 4);
    runUntilDrained(4, 50);
    applyStimulus();
    checkOutput("restart_count", rx_count_o, 32'd4);
    checkOutput("restart_level", 32'(level_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
